// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM download bus master.
package rom_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ERASE = 2'd1,
      LOAD  = 2'd2,
      WRITE = 2'd3
   } state_t;

   localparam logic [3:0] SEL_LO      = 4'b0011;
   localparam logic [3:0] SEL_HI      = 4'b1100;
   localparam logic [3:0] SEL_ALL     = 4'b1111;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;

endpackage

// File: rtl/rom_loader.sv
// Wishbone master/arbiter: zero-fills the erase window, then copies ioctl words
// into SDRAM during a ROM download; otherwise passes the core's bus through.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int          ERASE_AW  = 20,
   parameter int          LOAD_AW   = 20,
   parameter logic [23:0] LOAD_BASE = 24'h100000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        dl_active,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [15:0] ioctl_dout,
   output logic        ioctl_wait,
   output logic        rom_loaded,
   input  logic        core_stb,
   input  logic        core_cyc,
   input  logic        core_we,
   input  logic [3:0]  core_sel,
   input  logic [23:0] core_adr,
   input  logic [31:0] core_dat,
   input  logic [2:0]  core_cti,
   output logic        core_ack,
   output logic        wb_stb,
   output logic        wb_cyc,
   output logic        wb_we,
   output logic [3:0]  wb_sel,
   output logic [23:0] wb_adr,
   output logic [31:0] wb_dat,
   output logic [2:0]  wb_cti,
   input  logic        wb_ack
);

   state_t              r_state;
   logic [ERASE_AW-1:0] r_erase_addr;
   logic                r_stb;
   logic                r_wait;
   logic                r_loaded;
   logic                r_dl_d;
   logic                r_pend;
   logic [LOAD_AW-1:0]  r_ld_adr;
   logic                r_ld_hi;
   logic [15:0]         r_ld_dat;

   logic                w_dl_rise;
   logic                w_req;
   logic                w_core_busy;
   logic                w_ldr_ack;
   logic                w_accept_wr;
   logic [23:0]         w_ldr_adr;
   logic [3:0]          w_ldr_sel;
   logic [31:0]         w_ldr_dat;
   logic                w_unused_bits;

   assign w_dl_rise   = dl_active & ~r_dl_d;
   assign w_req       = w_dl_rise | (r_pend & dl_active);
   // A core cycle with its ack still outstanding must not be cut off.
   assign w_core_busy = core_cyc & core_stb & ~wb_ack;
   assign w_ldr_ack   = wb_ack & r_stb;
   assign w_accept_wr = (r_state == LOAD) & dl_active & ioctl_wr & ~ioctl_wait;

   assign ioctl_wait  = r_wait | r_stb;
   assign rom_loaded  = r_loaded;

   assign w_unused_bits = ^{ioctl_addr[24:LOAD_AW+2], ioctl_addr[0]};

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_erase_addr <= '0;
         r_stb        <= 1'b0;
         r_wait       <= 1'b0;
         r_loaded     <= 1'b0;
         r_dl_d       <= 1'b0;
         r_pend       <= 1'b0;
      end else begin
         r_dl_d <= dl_active;
         r_pend <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  if (w_core_busy) begin
                     r_pend <= 1'b1;
                  end else begin
                     r_state      <= ERASE;
                     r_erase_addr <= '0;
                     r_stb        <= 1'b1;
                     r_wait       <= 1'b1;
                     r_loaded     <= 1'b1;
                  end
               end
            end
            ERASE: begin
               if (w_ldr_ack) begin
                  if (!dl_active || (&r_erase_addr)) begin
                     r_state <= dl_active ? LOAD : IDLE;
                     r_stb   <= 1'b0;
                     r_wait  <= 1'b0;
                  end else begin
                     r_erase_addr <= r_erase_addr + ERASE_AW'(1);
                  end
               end
            end
            LOAD: begin
               if (!dl_active) begin
                  r_state <= IDLE;
               end else if (w_accept_wr) begin
                  r_state <= WRITE;
                  r_stb   <= 1'b1;
               end
            end
            WRITE: begin
               if (w_ldr_ack) begin
                  r_state <= dl_active ? LOAD : IDLE;
                  r_stb   <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_stb   <= 1'b0;
               r_wait  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (w_accept_wr) begin
         r_ld_adr <= ioctl_addr[LOAD_AW+1:2];
         r_ld_hi  <= ioctl_addr[1];
         r_ld_dat <= ioctl_dout;
      end
   end

   always_comb begin
      w_ldr_adr = LOAD_BASE | 24'(r_ld_adr);
      w_ldr_sel = r_ld_hi ? SEL_HI : SEL_LO;
      w_ldr_dat = {r_ld_dat, r_ld_dat};
      if (r_state == ERASE) begin
         w_ldr_adr = 24'(r_erase_addr);
         w_ldr_sel = SEL_ALL;
         w_ldr_dat = '0;
      end
   end

   // Bus ownership: core only in IDLE, loader everywhere else.
   always_comb begin
      wb_stb   = core_stb;
      wb_cyc   = core_cyc;
      wb_we    = core_we;
      wb_sel   = core_sel;
      wb_adr   = core_adr;
      wb_dat   = core_dat;
      wb_cti   = core_cti;
      core_ack = wb_ack;
      if (r_state != IDLE) begin
         wb_stb   = r_stb;
         wb_cyc   = r_stb;
         wb_we    = 1'b1;
         wb_sel   = w_ldr_sel;
         wb_adr   = w_ldr_adr;
         wb_dat   = w_ldr_dat;
         wb_cti   = CTI_CLASSIC;
         core_ack = 1'b0;
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: wishbone slave model, write log and directed/random download steps.
module tb_rom_loader;

   localparam int          ERASE_AW  = 4;
   localparam int          LOAD_AW   = 20;
   localparam logic [23:0] LOAD_BASE = 24'h100000;

   logic        clk_sys;
   logic        reset_n;
   logic        dl_active;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [15:0] ioctl_dout;
   logic        ioctl_wait;
   logic        rom_loaded;
   logic        core_stb, core_cyc, core_we;
   logic [3:0]  core_sel;
   logic [23:0] core_adr;
   logic [31:0] core_dat;
   logic [2:0]  core_cti;
   logic        core_ack;
   logic        wb_stb, wb_cyc, wb_we;
   logic [3:0]  wb_sel;
   logic [23:0] wb_adr;
   logic [31:0] wb_dat;
   logic [2:0]  wb_cti;
   logic        wb_ack;

   typedef struct {
      logic [23:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        we;
   } wr_t;

   wr_t log_q[$];
   int  n_checks = 0;
   int  n_err    = 0;
   int  ack_dly  = 2;
   int  slv_cnt;
   int  core_ack_cnt;

   rom_loader #(
      .ERASE_AW (ERASE_AW),
      .LOAD_AW  (LOAD_AW),
      .LOAD_BASE(LOAD_BASE)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .dl_active (dl_active),
      .ioctl_wr  (ioctl_wr),
      .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait),
      .rom_loaded(rom_loaded),
      .core_stb  (core_stb),
      .core_cyc  (core_cyc),
      .core_we   (core_we),
      .core_sel  (core_sel),
      .core_adr  (core_adr),
      .core_dat  (core_dat),
      .core_cti  (core_cti),
      .core_ack  (core_ack),
      .wb_stb    (wb_stb),
      .wb_cyc    (wb_cyc),
      .wb_we     (wb_we),
      .wb_sel    (wb_sel),
      .wb_adr    (wb_adr),
      .wb_dat    (wb_dat),
      .wb_cti    (wb_cti),
      .wb_ack    (wb_ack)
   );

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // SDRAM slave: single-cycle ack ack_dly edges after stb is seen.
   always @(posedge clk_sys) begin
      if (!reset_n) begin
         wb_ack  <= 1'b0;
         slv_cnt <= 0;
      end else if (wb_ack) begin
         wb_ack  <= 1'b0;
         slv_cnt <= 0;
      end else if (wb_stb && wb_cyc) begin
         if (slv_cnt >= ack_dly - 1) wb_ack <= 1'b1;
         else slv_cnt <= slv_cnt + 1;
      end else begin
         slv_cnt <= 0;
      end
   end

   always @(posedge clk_sys) begin
      if (reset_n && wb_stb && wb_cyc && wb_ack)
         log_q.push_back('{adr: wb_adr, sel: wb_sel, dat: wb_dat, we: wb_we});
   end

   always @(posedge clk_sys) begin
      if (!reset_n) core_ack_cnt <= 0;
      else if (core_ack) core_ack_cnt <= core_ack_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [24:0] a, input logic [15:0] d,
                          input logic [23:0] eadr, input logic [3:0] esel,
                          input logic [31:0] edat, input bit inject);
      bit wait_ok;
      log_q.delete();
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      chk("wait_after_wr", ioctl_wait, 1);
      if (inject) begin
         ioctl_addr = a ^ 25'h000010;
         ioctl_dout = ~d;
         ioctl_wr   = 1'b1;
         @(negedge clk_sys);
         ioctl_wr = 1'b0;
      end
      wait_ok = 1'b1;
      for (int i = 0; i < 100 && log_q.size() == 0; i++) begin
         if (ioctl_wait !== 1'b1) wait_ok = 1'b0;
         @(negedge clk_sys);
      end
      chk("wait_hold", wait_ok, 1);
      chk("load_count", log_q.size(), 1);
      chk("wait_release", ioctl_wait, 0);
      if (log_q.size() > 0) begin
         chk("load_adr", log_q[0].adr, eadr);
         chk("load_sel", log_q[0].sel, esel);
         chk("load_dat", log_q[0].dat, edat);
         chk("load_we", log_q[0].we, 1);
      end
      repeat (6) @(negedge clk_sys);
      chk("single_write", log_q.size(), 1);
   endtask

   initial begin
      bit          wait_ok, noack_ok, cti_ok;
      logic [24:0] ra;
      logic [15:0] rd;
      logic [23:0] m_adr;
      logic [3:0]  m_sel;

      reset_n    = 1'b0;
      dl_active  = 1'b0;
      ioctl_wr   = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      core_stb   = 1'b0;
      core_cyc   = 1'b0;
      core_we    = 1'b0;
      core_sel   = 4'hF;
      core_adr   = 24'h00ABCD;
      core_dat   = 32'h1234_5678;
      core_cti   = 3'b010;
      repeat (3) @(negedge clk_sys);

      chk("rst_wait", ioctl_wait, 0);
      chk("rst_loaded", rom_loaded, 0);
      chk("rst_stb", wb_stb, 0);
      core_adr = 24'($urandom);
      core_dat = $urandom;
      #1;
      chk("rst_pass_adr", wb_adr, core_adr);
      chk("rst_pass_dat", wb_dat, core_dat);
      chk("rst_pass_cti", wb_cti, 3'b010);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // Core read in flight when the download begins.
      core_cti = 3'b000;
      core_adr = 24'h000020;
      core_we  = 1'b0;
      core_cyc = 1'b1;
      core_stb = 1'b1;
      dl_active = 1'b1;
      for (int i = 0; i < 50 && core_ack !== 1'b1; i++) @(negedge clk_sys);
      chk("core_ack_first", core_ack, 1);
      chk("core_owns_bus", wb_adr, 24'h000020);
      @(posedge clk_sys);
      #1;
      log_q.delete();
      chk("core_ack_cnt1", core_ack_cnt, 1);

      wait_ok  = 1'b1;
      noack_ok = 1'b1;
      cti_ok   = 1'b1;
      for (int i = 0; i < 400 && log_q.size() < 16; i++) begin
         @(negedge clk_sys);
         if (log_q.size() < 16) begin
            if (ioctl_wait !== 1'b1) wait_ok = 1'b0;
            if (core_ack !== 1'b0) noack_ok = 1'b0;
            if (wb_cti !== 3'b000) cti_ok = 1'b0;
         end
      end
      chk("erase_count", log_q.size(), 16);
      for (int k = 0; k < 16 && k < log_q.size(); k++) begin
         chk("erase_adr", log_q[k].adr, 24'(k));
         chk("erase_sel", log_q[k].sel, 4'hF);
         chk("erase_dat", log_q[k].dat, 32'h0);
         chk("erase_we", log_q[k].we, 1);
      end
      chk("erase_wait_high", wait_ok, 1);
      chk("erase_no_core_ack", noack_ok, 1);
      chk("erase_cti", cti_ok, 1);
      chk("erase_wait_low", ioctl_wait, 0);
      chk("loaded_set", rom_loaded, 1);
      chk("core_ack_cnt_erase", core_ack_cnt, 1);
      core_stb = 1'b0;
      core_cyc = 1'b0;

      do_load(25'h000006, 16'hBEEF, 24'h100001, 4'b1100, 32'hBEEFBEEF, 1'b0);
      ack_dly = 3;
      do_load(25'h400004, 16'h1234, 24'h100001, 4'b0011, 32'h12341234, 1'b1);

      for (int n = 0; n < 6; n++) begin
         ra      = 25'($urandom);
         rd      = 16'($urandom);
         ack_dly = $urandom_range(1, 4);
         m_adr   = LOAD_BASE | 24'((ra / 4) % (1 << LOAD_AW));
         m_sel   = ((ra / 2) % 2 == 1) ? 4'b1100 : 4'b0011;
         do_load(ra, rd, m_adr, m_sel, {rd, rd}, 1'b0);
      end

      // Download ends while a write is waiting for its ack.
      ack_dly = 5;
      log_q.delete();
      ioctl_addr = 25'h000008;
      ioctl_dout = 16'hCAFE;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr  = 1'b0;
      dl_active = 1'b0;
      for (int i = 0; i < 100 && log_q.size() == 0; i++) @(negedge clk_sys);
      chk("drop_count", log_q.size(), 1);
      if (log_q.size() > 0) begin
         chk("drop_adr", log_q[0].adr, 24'h100002);
         chk("drop_sel", log_q[0].sel, 4'b0011);
         chk("drop_dat", log_q[0].dat, 32'hCAFECAFE);
      end
      chk("drop_idle_stb", wb_stb, 0);
      chk("drop_wait", ioctl_wait, 0);
      core_adr = 24'h000010;
      core_we  = 1'b0;
      core_sel = 4'hF;
      core_cyc = 1'b1;
      core_stb = 1'b1;
      #1;
      chk("drop_pass_adr", wb_adr, 24'h000010);
      chk("drop_pass_stb", wb_stb, 1);
      for (int i = 0; i < 50 && core_ack !== 1'b1; i++) @(negedge clk_sys);
      chk("drop_core_ack", core_ack, 1);
      @(posedge clk_sys);
      #1;
      core_stb = 1'b0;
      core_cyc = 1'b0;
      chk("core_ack_cnt2", core_ack_cnt, 2);

      // Reset in the middle of an erase.
      ack_dly = 2;
      @(negedge clk_sys);
      log_q.delete();
      dl_active = 1'b1;
      for (int i = 0; i < 100 && log_q.size() < 3; i++) @(negedge clk_sys);
      chk("mid_erase_progress", (log_q.size() >= 3), 1);
      chk("mid_erase_loaded", rom_loaded, 1);
      reset_n   = 1'b0;
      dl_active = 1'b0;
      core_adr  = 24'h0055AA;
      @(negedge clk_sys);
      chk("rst2_stb", wb_stb, 0);
      chk("rst2_cyc", wb_cyc, 0);
      chk("rst2_wait", ioctl_wait, 0);
      chk("rst2_loaded", rom_loaded, 0);
      chk("rst2_pass_adr", wb_adr, 24'h0055AA);
      chk("rst2_core_ack", core_ack, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("rst2_loaded_after", rom_loaded, 0);
      chk("rst2_wait_after", ioctl_wait, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Wishbone bus master and arbiter between the HPS ioctl download port and the SDRAM wishbone slave.
- On a ROM download, it first zero-fills the erase window, then writes each 16-bit ioctl word into SDRAM at the load base.
- Outside downloads it passes the CPU core's wishbone bus straight through.
- It also raises a sticky "ROM loaded" flag that gates release of the system reset.

Parameters:
- ERASE_AW, 20, erase window width in 32-bit words (2^ERASE_AW words cleared, starting at word 0).
- LOAD_AW, 20, ioctl word-address bits used (ioctl_addr[LOAD_AW+1:2]); higher bits ignored, so addresses wrap.
- LOAD_BASE, 24'h100000, word address OR'd onto the load offset.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dl_active  in  1  ROM download in progress (index match AND ioctl_download).
- ioctl_wr  in  1  one-cycle write strobe from HPS.
- ioctl_addr  in  25  byte address of the ioctl word.
- ioctl_dout  in  16  ioctl data.
- ioctl_wait  out  1  holds off HPS writes.
- rom_loaded  out  1  sticky; set when a download starts.
- core_stb, core_cyc, core_we  in  1 each  core wishbone master.
- core_sel  in  4;  core_adr  in  24 ([25:2]);  core_dat  in  32;  core_cti  in  3.
- core_ack  out  1  ack returned to the core.
- wb_stb, wb_cyc, wb_we  out  1 each  to SDRAM.
- wb_sel  out  4;  wb_adr  out  24;  wb_dat  out  32;  wb_cti  out  3.
- wb_ack  in  1  SDRAM ack; single-cycle pulse.

Behaviour:
- Reset: on reset_n=0, state=IDLE; ldr_stb=0, ioctl_wait=0, rom_loaded=0, erase_addr=0. Any in-flight loader cycle is abandoned, with stb dropped the next cycle.
- States and transitions:
  - IDLE. Bus owned by the core. Rising edge of dl_active → ERASE with erase_addr=0, ldr_stb=1, ioctl_wait=1, rom_loaded=1.
  - ERASE. Drives we=1, sel=4'b1111, dat=0, adr={zero-extend erase_addr}, stb=cyc=1. On wb_ack:
    - if erase_addr == 2^ERASE_AW−1 → LOAD, ldr_stb=0, ioctl_wait=0;
    - otherwise erase_addr+1 with stb held high, so the new address is presented the cycle after ack.
  - LOAD. Waits for ioctl_wr. On ioctl_wr, latches addr and data → WRITE with ldr_stb=1.
  - WRITE. Drives we=1, adr=LOAD_BASE | ioctl_addr[LOAD_AW+1:2], dat={dout,dout}, sel = addr[1] ? 4'b1100 : 4'b0011. On wb_ack → LOAD, ldr_stb=0.
- ioctl_wait: registered ioctl_wait OR ldr_stb, so it is high for the whole ERASE phase and from the cycle after ioctl_wr until the cycle after ack.
- ioctl_wr arriving while ioctl_wait=1 is ignored (HPS protocol violation). ioctl_addr[0] is ignored.
- dl_active falling:
  - in LOAD → IDLE the next cycle;
  - in WRITE → finish the current cycle (await ack), then IDLE;
  - in ERASE → finish the current word, then IDLE, without completing the erase.
- Arbitration: the loader owns the bus in every state except IDLE.
  - While the loader owns it, core_ack=0 and the core's request is held off.
  - In IDLE, all wb_* outputs equal the core_* inputs combinationally and core_ack=wb_ack.
  - The loader drives wb_cti=3'b000 (classic cycles).
  - The ownership change happens only between cycles; the loader never takes the bus while core_cyc=1 with an ack outstanding. An IDLE→ERASE request made in that situation is deferred until the core's ack.
- rom_loaded is cleared only by reset_n.
- Width rule: erase_addr is ERASE_AW bits; the wrap test is all-ones.

Decomposition:
- Package rom_loader_pkg holds: the state enum (IDLE, ERASE, LOAD, WRITE), the SEL_LO/SEL_HI/SEL_ALL constants, and CTI_CLASSIC.
- No sub-module: the arbiter mux is inline combinational logic in the same file.

Test Plan:
- ERASE_AW=4, slave acks every word after 2 cycles; pulse dl_active → exactly 16 writes at adr 0..15, sel=F, dat=0; ioctl_wait high throughout and low one cycle after the 16th ack; rom_loaded=1.
- After erase, ioctl_wr with addr=0x000006, dout=16'hBEEF → one write at adr=0x100001, sel=4'b1100, dat=32'hBEEFBEEF; ioctl_wait high until the cycle after ack.
- ioctl_addr=0x400004 with LOAD_AW=20 → wraps to adr=0x100001; sel=4'b0011.
- Drop dl_active while a WRITE awaits ack (ack delayed 5 cycles) → the write completes, then the bus returns to the core; a core read to 0x000010 acks with core_ack=1.
- Core cycle in progress when dl_active rises → the core's ack is delivered first, then the erase starts; no core_ack during erase even with core_stb=1.
- Assert reset_n=0 mid-erase → next cycle wb_stb=0, ioctl_wait=0, rom_loaded=0, state IDLE, bus in passthrough.
